// File: rtl/fpu_pkg.sv
// fpu_issue shared constants, flag indices and state encoding.
// Imported by fpu_classify and fpu_issue.
package fpu_pkg;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  localparam int FLG_BYPASS  = 0;
  localparam int FLG_INVALID = 1;
  localparam int FLG_TIMEOUT = 2;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    ISSUE     = ST_ISSUE,
    WAIT_ACK  = ST_WAIT_ACK,
    WAIT_DONE = ST_WAIT_DONE,
    RESP      = ST_RESP
  } state_t;
endpackage

// File: rtl/fpu_classify.sv
// Combinational IEEE special-case classifier for add/sub requests.
// In: a, b, op. Out: is_bypass, invalid, bypass_result.
module fpu_classify
  import fpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        is_bypass,
  output logic        invalid,
  output logic [31:0] bypass_result
);
  logic eb;
  logic a_max, b_max;
  logic a_nan, b_nan;
  logic a_inf, b_inf;
  logic a_zero, b_zero;

  assign eb     = b[31] ^ op;
  assign a_max  = (a[30:23] == FP_EXP_MAX);
  assign b_max  = (b[30:23] == FP_EXP_MAX);
  assign a_nan  = a_max && (a[22:0] != 23'd0);
  assign b_nan  = b_max && (b[22:0] != 23'd0);
  assign a_inf  = a_max && (a[22:0] == 23'd0);
  assign b_inf  = b_max && (b[22:0] == 23'd0);
  assign a_zero = (a[30:0] == 31'd0);
  assign b_zero = (b[30:0] == 31'd0);

  always_comb begin
    is_bypass     = 1'b1;
    invalid       = 1'b0;
    bypass_result = FP_QNAN;
    if (a_nan || b_nan) begin
      invalid = 1'b1;
    end else if (a_inf && b_inf && (a[31] != eb)) begin
      invalid = 1'b1;
    end else if (a_inf) begin
      bypass_result = a;
    end else if (b_inf) begin
      bypass_result = {eb, b[30:0]};
    end else if (a_zero && b_zero) begin
      // -0 only when both effective signs are negative
      bypass_result = {a[31] & eb, 31'd0};
    end else begin
      is_bypass = 1'b0;
    end
  end
endmodule

// File: rtl/fpu_issue.sv
// Request front-end for the fpu add/sub core: bypass, issue, timeout.
// Ports: in_* request, core_* core handshake, out_* response.
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        core_start,
  output logic        core_op,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic        core_ready,
  input  logic [31:0] core_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_c,
  output logic [2:0]  out_flags
);
  state_t      state, state_d;
  logic [TW-1:0] cnt, cnt_d, cnt_inc;
  logic        tmo;
  logic        load_core;
  logic [31:0] out_d;
  logic [2:0]  flg_d;
  logic        is_bypass, invalid;
  logic [31:0] bypass_result;
  logic [2:0]  tmo_flags;

  fpu_classify u_cls (
    .a             (in_a),
    .b             (in_b),
    .op            (in_op),
    .is_bypass     (is_bypass),
    .invalid       (invalid),
    .bypass_result (bypass_result)
  );

  assign cnt_inc    = cnt + 1'b1;
  assign tmo        = (cnt_inc == TW'(TIMEOUT_CYCLES));
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == RESP);
  assign core_start = (state == ISSUE) || (state == WAIT_ACK);

  always_comb begin
    tmo_flags = '0;
    tmo_flags[FLG_TIMEOUT] = 1'b1;
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    load_core = 1'b0;
    out_d     = out_c;
    flg_d     = out_flags;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (is_bypass) begin
            out_d = bypass_result;
            flg_d = '0;
            flg_d[FLG_BYPASS]  = 1'b1;
            flg_d[FLG_INVALID] = invalid;
            state_d = RESP;
          end else begin
            load_core = 1'b1;
            cnt_d     = '0;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d = cnt_inc;
        if (tmo) begin
          out_d   = FP_QNAN;
          flg_d   = tmo_flags;
          state_d = RESP;
        end else if (core_ready) begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        cnt_d = cnt_inc;
        if (tmo) begin
          out_d   = FP_QNAN;
          flg_d   = tmo_flags;
          state_d = RESP;
        end else if (!core_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_inc;
        // a result arriving on the timeout cycle still wins
        if (core_ready) begin
          out_d   = core_c;
          flg_d   = '0;
          state_d = RESP;
        end else if (tmo) begin
          out_d   = FP_QNAN;
          flg_d   = tmo_flags;
          state_d = RESP;
        end
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_c     <= '0;
      out_flags <= '0;
      core_a    <= '0;
      core_b    <= '0;
      core_op   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      out_c     <= out_d;
      out_flags <= flg_d;
      if (load_core) begin
        core_a  <= in_a;
        core_b  <= in_b;
        core_op <= in_op;
      end
    end
  end
endmodule
